// File: rtl/mem_port_arbiter_if.sv
// Shared bus between the CPU fetch/data ports, the arbiter and the unified RAM.
// slave: arbiter side; master: CPU + RAM side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_cs;
  logic        d_r;
  logic        d_w;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, d_cs, d_r, d_w, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_cs, d_r, d_w, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one fixed-latency synchronous RAM; data has priority.
// Optional single-entry fetch buffer enabled by defining MEM_ARB_IBUF_EN.
module mem_port_arbiter #(
  parameter int unsigned LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        sel_d;
  logic        is_wr;
  logic [31:0] last_addr, last_wdata;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        d_req, grant_d, grant_if, cnt_last, hit_ok;

  assign d_req    = bus.d_cs & (bus.d_r | bus.d_w);
  assign cnt_last = (cnt <= 4'd1);

`ifdef MEM_ARB_IBUF_EN
  logic [31:2] ibuf_addr;
  logic [31:0] ibuf_data;
  logic        ibuf_valid;
  logic        ibuf_hit;
  assign hit_ok   = ibuf_valid & (ibuf_addr == bus.if_addr[31:2]);
  assign ibuf_hit = (state == IDLE) & ~d_req & bus.if_req & hit_ok;
`else
  assign hit_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (d_req) begin
            grant_d   = 1'b1;
            state_nxt = D_BUSY;
          end else if (bus.if_req) begin
            if (hit_ok) begin
              state_nxt = DONE;
            end else begin
              grant_if  = 1'b1;
              state_nxt = IF_BUSY;
            end
          end
        end
      end
      IF_BUSY, D_BUSY: if (cnt_last) state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // RAM strobes only in the grant cycle; address/wdata hold the last grant otherwise.
  assign bus.mem_en    = grant_d | grant_if;
  assign bus.mem_we    = grant_d & bus.d_w;
  assign bus.mem_addr  = grant_d ? bus.d_addr : (grant_if ? bus.if_addr : last_addr);
  assign bus.mem_wdata = grant_d ? bus.d_wdata : last_wdata;

  assign bus.if_ready = (state == DONE) & ~sel_d;
  assign bus.d_ready  = (state == DONE) &  sel_d;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.stall    = ~rst & ((bus.if_req & ~bus.if_ready) | (d_req & ~bus.d_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sel_d      <= 1'b0;
      is_wr      <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_IBUF_EN
      ibuf_addr  <= '0;
      ibuf_data  <= '0;
      ibuf_valid <= 1'b0;
`endif
    end else begin
      if (grant_d) begin
        cnt        <= LAT_C;
        sel_d      <= 1'b1;
        is_wr      <= bus.d_w;
        last_addr  <= bus.d_addr;
        last_wdata <= bus.d_wdata;
      end
      if (grant_if) begin
        cnt       <= LAT_C;
        sel_d     <= 1'b0;
        last_addr <= bus.if_addr;
      end
      if (state == IF_BUSY || state == D_BUSY) begin
        cnt <= cnt - 4'd1;
        if (cnt_last) begin
          if (state == IF_BUSY) if_rdata_q <= bus.mem_rdata;
          else if (!is_wr)      d_rdata_q  <= bus.mem_rdata;
        end
      end
`ifdef MEM_ARB_IBUF_EN
      if (ibuf_hit) begin
        sel_d      <= 1'b0;
        if_rdata_q <= ibuf_data;
      end
      if (state == IF_BUSY && cnt_last) begin
        ibuf_valid <= 1'b1;
        ibuf_addr  <= last_addr[31:2];
        ibuf_data  <= bus.mem_rdata;
      end
      // A write to the buffered word makes the entry stale.
      if (grant_d && bus.d_w && bus.d_addr[31:2] == ibuf_addr) ibuf_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-table bench for mem_port_arbiter (LAT=3 instance) plus hand sequences
// for the fetch buffer path and a LAT=1 instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus3();
  mem_port_arbiter_if bus1();

  mem_port_arbiter #(.LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  mem_port_arbiter #(.LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_0005;
    return {16'hC0DE, a[15:0]};
  endfunction

  // RAM models: data valid exactly LAT cycles after mem_en, junk otherwise.
  logic [31:0] p3 [3];
  logic [31:0] p1;
  always @(posedge clk) begin
    p3[0] <= bus3.mem_en ? rd(bus3.mem_addr) : 32'hBAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    p1    <= bus1.mem_en ? rd(bus1.mem_addr) : 32'hBAD1_BAD1;
  end
  assign bus3.mem_rdata = p3[2];
  assign bus1.mem_rdata = p1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, if_req;
    logic [31:0] if_addr;
    logic        d_cs, d_r, d_w;
    logic [31:0] d_addr, d_wdata;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_ir, e_dr;
    logic [31:0] e_ird, e_drd;
    logic        e_stall, full;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic r, iq, input logic [31:0] ia, input logic cs, dr_, dw_,
    input logic [31:0] da, dwd,
    input logic en, we, input logic [31:0] ma, mw, input logic ir, drdy,
    input logic [31:0] ird, drd, input logic st, full);
    vec_t x;
    x.rst = r; x.if_req = iq; x.if_addr = ia; x.d_cs = cs; x.d_r = dr_; x.d_w = dw_;
    x.d_addr = da; x.d_wdata = dwd; x.e_en = en; x.e_we = we; x.e_addr = ma;
    x.e_wdata = mw; x.e_ir = ir; x.e_dr = drdy; x.e_ird = ird; x.e_drd = drd;
    x.e_stall = st; x.full = full;
    return x;
  endfunction

  task automatic idle_in3();
    bus3.if_req = 0; bus3.if_addr = 0; bus3.d_cs = 0; bus3.d_r = 0; bus3.d_w = 0;
    bus3.d_addr = 0; bus3.d_wdata = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] K0 = 32'hC0DE_0100;
  localparam logic [31:0] K1 = 32'hC0DE_0080;
  localparam logic [31:0] KI = 32'h2008_0005;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  initial begin
    idle_in3();
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_cs = 0; bus1.d_r = 0; bus1.d_w = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;

    //           rst iq ia     cs r w da     dw      en we ma     mw     ir dr ird dr  st full
    tv.push_back(v(1,0,32'h0,  0,0,0,32'h0,  32'h0,  0,0,32'h0, 32'h0, 0,0,0, 0,  0,0));
    tv.push_back(v(1,0,32'h0,  0,0,0,32'h0,  32'h0,  0,0,32'h0, 32'h0, 0,0,0, 0,  0,1));
    // simultaneous fetch + data read: data first
    tv.push_back(v(0,1,32'h80, 1,1,0,32'h100,32'h0,  1,0,32'h100,32'h0,0,0,0, 0,  1,1));
    for (int k = 0; k < 3; k++)
      tv.push_back(v(0,1,32'h80,1,1,0,32'h100,32'h0, 0,0,32'h100,32'h0,0,0,0, 0,  1,1));
    tv.push_back(v(0,1,32'h80, 1,1,0,32'h100,32'h0,  0,0,32'h100,32'h0,0,1,0, K0, 1,1));
    tv.push_back(v(0,1,32'h80, 0,0,0,32'h0,  32'h0,  1,0,32'h80, 32'h0,0,0,0, K0, 1,1));
    for (int k = 0; k < 3; k++)
      tv.push_back(v(0,1,32'h80,0,0,0,32'h0, 32'h0,  0,0,32'h80, 32'h0,0,0,0, K0, 1,1));
    tv.push_back(v(0,1,32'h80, 0,0,0,32'h0,  32'h0,  0,0,32'h80, 32'h0,1,0,K1,K0, 0,1));
    tv.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,  0,0,32'h80, 32'h0,0,0,K1,K0, 0,1));
    // write with d_r also set
    tv.push_back(v(0,0,32'h0,  1,1,1,32'h200,DB,     1,1,32'h200,DB,   0,0,K1,K0, 1,1));
    for (int k = 0; k < 3; k++)
      tv.push_back(v(0,0,32'h0,1,1,1,32'h200,DB,     0,0,32'h200,DB,   0,0,K1,K0, 1,1));
    tv.push_back(v(0,0,32'h0,  1,1,1,32'h200,DB,     0,0,32'h200,DB,   0,1,K1,K0, 0,1));
    // chip select without r/w is not a request
    tv.push_back(v(0,0,32'h0,  1,0,0,32'h300,32'h0,  0,0,32'h200,DB,   0,0,K1,K0, 0,1));
    tv.push_back(v(0,0,32'h0,  1,0,0,32'h300,32'h0,  0,0,32'h200,DB,   0,0,K1,K0, 0,1));
    // fetch aborted by reset, then re-requested
    tv.push_back(v(0,1,32'h40, 0,0,0,32'h0,  32'h0,  1,0,32'h40, DB,   0,0,K1,K0, 1,1));
    tv.push_back(v(1,1,32'h40, 0,0,0,32'h0,  32'h0,  0,0,32'h0,  32'h0,0,0,0, 0,  0,0));
    tv.push_back(v(1,1,32'h40, 0,0,0,32'h0,  32'h0,  0,0,32'h0,  32'h0,0,0,0, 0,  0,1));
    tv.push_back(v(0,1,32'h40, 0,0,0,32'h0,  32'h0,  1,0,32'h40, 32'h0,0,0,0, 0,  1,1));
    for (int k = 0; k < 3; k++)
      tv.push_back(v(0,1,32'h40,0,0,0,32'h0, 32'h0,  0,0,32'h40, 32'h0,0,0,0, 0,  1,1));
    tv.push_back(v(0,1,32'h40, 0,0,0,32'h0,  32'h0,  0,0,32'h40, 32'h0,1,0,KI,0,  0,1));
    tv.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,  0,0,32'h40, 32'h0,0,0,KI,0,  0,1));

    for (int i = 0; i < tv.size(); i++) begin
      if (i > 0) cyc();
      rst = tv[i].rst;
      bus3.if_req = tv[i].if_req; bus3.if_addr = tv[i].if_addr;
      bus3.d_cs = tv[i].d_cs; bus3.d_r = tv[i].d_r; bus3.d_w = tv[i].d_w;
      bus3.d_addr = tv[i].d_addr; bus3.d_wdata = tv[i].d_wdata;
      @(negedge clk);
      chk($sformatf("row%0d mem_en", i),   32'(bus3.mem_en),   32'(tv[i].e_en));
      chk($sformatf("row%0d mem_we", i),   32'(bus3.mem_we),   32'(tv[i].e_we));
      chk($sformatf("row%0d if_ready", i), 32'(bus3.if_ready), 32'(tv[i].e_ir));
      chk($sformatf("row%0d d_ready", i),  32'(bus3.d_ready),  32'(tv[i].e_dr));
      chk($sformatf("row%0d stall", i),    32'(bus3.stall),    32'(tv[i].e_stall));
      if (tv[i].full) begin
        chk($sformatf("row%0d mem_addr", i),  bus3.mem_addr,  tv[i].e_addr);
        chk($sformatf("row%0d mem_wdata", i), bus3.mem_wdata, tv[i].e_wdata);
        chk($sformatf("row%0d if_rdata", i),  bus3.if_rdata,  tv[i].e_ird);
        chk($sformatf("row%0d d_rdata", i),   bus3.d_rdata,   tv[i].e_drd);
      end
    end

    // Re-fetch of 0x40 (buffered when the fetch buffer is built in).
    cyc(); bus3.if_req = 1; bus3.if_addr = 32'h40;
    @(negedge clk);
`ifdef MEM_ARB_IBUF_EN
    chk("refetch mem_en", 32'(bus3.mem_en), 32'd0);
    chk("refetch stall", 32'(bus3.stall), 32'd1);
    cyc(); @(negedge clk);
`else
    chk("refetch mem_en", 32'(bus3.mem_en), 32'd1);
    for (int k = 0; k < 4; k++) begin cyc(); @(negedge clk); end
`endif
    chk("refetch if_ready", 32'(bus3.if_ready), 32'd1);
    chk("refetch if_rdata", bus3.if_rdata, KI);
    cyc(); idle_in3();

    // Write to 0x40 must invalidate any buffered copy.
    cyc(); bus3.d_cs = 1; bus3.d_w = 1; bus3.d_addr = 32'h40; bus3.d_wdata = 32'h1111_2222;
    @(negedge clk);
    chk("wr40 mem_en", 32'(bus3.mem_en), 32'd1);
    chk("wr40 mem_we", 32'(bus3.mem_we), 32'd1);
    for (int k = 0; k < 4; k++) begin cyc(); @(negedge clk); end
    chk("wr40 d_ready", 32'(bus3.d_ready), 32'd1);
    chk("wr40 d_rdata", bus3.d_rdata, 32'h0);
    cyc(); idle_in3();
    cyc(); bus3.if_req = 1; bus3.if_addr = 32'h40;
    @(negedge clk);
    chk("fetch after wr mem_en", 32'(bus3.mem_en), 32'd1);
    chk("fetch after wr mem_addr", bus3.mem_addr, 32'h40);
    for (int k = 0; k < 4; k++) begin cyc(); @(negedge clk); end
    chk("fetch after wr if_ready", 32'(bus3.if_ready), 32'd1);
    chk("fetch after wr if_rdata", bus3.if_rdata, KI);
    cyc(); idle_in3();

    // LAT=1 fetch: grant T, ready T+2.
    cyc(); bus1.if_req = 1; bus1.if_addr = 32'h40;
    @(negedge clk);
    chk("lat1 T mem_en", 32'(bus1.mem_en), 32'd1);
    chk("lat1 T mem_addr", bus1.mem_addr, 32'h40);
    cyc(); @(negedge clk);
    chk("lat1 T+1 mem_en", 32'(bus1.mem_en), 32'd0);
    chk("lat1 T+1 if_ready", 32'(bus1.if_ready), 32'd0);
    chk("lat1 T+1 stall", 32'(bus1.stall), 32'd1);
    cyc(); @(negedge clk);
    chk("lat1 T+2 if_ready", 32'(bus1.if_ready), 32'd1);
    chk("lat1 T+2 if_rdata", bus1.if_rdata, KI);
    chk("lat1 T+2 stall", 32'(bus1.stall), 32'd0);
    cyc(); bus1.if_req = 0;
    @(negedge clk);
    chk("lat1 after if_ready", 32'(bus1.if_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
